vi_mem_arbiter: RTL and testbench

Shares vi_core's single external memory port between the instruction-cache refill path and the data-cache path (line refills plus word/byte stores). Sits between the two caches and the memory interface (`mem_*`). Keeps at most one read outstanding, routes each returned 128-bit line to the requester that issued it, and issues store writes as single-cycle pulses.

---
 rtl/vi_mem_pkg.sv | 32 +++
 rtl/vi_mem_arbiter_if.sv | 48 ++++
 rtl/vi_mem_arb_pick.sv | 72 +++++++
 rtl/vi_mem_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_vi_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vi_mem_pkg.sv
// -----------------------------------------------------------------------------
// vi_mem_pkg
// Shared constants and types for the vi_core memory-port arbiter.
//   ADDR_W / LINE_W / WORD_W : byte address, memory line and store word widths
//   state_t                  : arbiter FSM states
//   owner_t                  : which cache owns the transaction in flight
// -----------------------------------------------------------------------------
package vi_mem_pkg;

  localparam int ADDR_W = 20;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IC,
    OWN_DC
  } owner_t;

  // The requester that should be favoured after `o` has been granted.
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_IC) ? OWN_DC : OWN_IC;
  endfunction

endpackage

// File: rtl/vi_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// vi_mem_arbiter_if
// The single external memory port of vi_core.
//   master modport : arbiter side (issues read/write strobes, takes responses)
//   slave modport  : memory side
// Read channel : mem_read strobe + mem_read_addr
// Write channel: mem_write_enable strobe + byte qualifier, address and data
// Response     : mem_data_ready + mem_data, with the request address echoed
//                on mem_addr
// -----------------------------------------------------------------------------
interface vi_mem_arbiter_if;
  import vi_mem_pkg::*;

  logic              mem_read;
  logic [ADDR_W-1:0] mem_read_addr;
  logic              mem_write_enable;
  logic              mem_write_byte;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [WORD_W-1:0] mem_write_data;
  logic              mem_data_ready;
  logic [LINE_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_addr;

  modport master (
    output mem_read,
    output mem_read_addr,
    output mem_write_enable,
    output mem_write_byte,
    output mem_write_addr,
    output mem_write_data,
    input  mem_data_ready,
    input  mem_data,
    input  mem_addr
  );

  modport slave (
    input  mem_read,
    input  mem_read_addr,
    input  mem_write_enable,
    input  mem_write_byte,
    input  mem_write_addr,
    input  mem_write_data,
    output mem_data_ready,
    output mem_data,
    output mem_addr
  );

endinterface

// File: rtl/vi_mem_arb_pick.sv
// -----------------------------------------------------------------------------
// vi_mem_arb_pick
// Combinational 2-way picker between the I-cache and the D-cache.
// Build option: VI_MEM_ARB_RR_EN
//   defined   : round-robin; a pointer register holds who wins the next tie
//               and flips only when a grant is actually taken
//   undefined : fixed priority, D-cache over I-cache (no state, no clock)
// Ports:
//   clk_i, rsn_i : clock / async active-low reset (round-robin build only)
//   en_i         : the arbiter is able to accept a request this cycle
//   ic_req_i     : I-cache wants the port
//   dc_req_i     : D-cache wants the port (read or store)
//   valid_o      : a grant is taken this cycle
//   owner_o      : winner, meaningful when valid_o is high
// -----------------------------------------------------------------------------
module vi_mem_arb_pick
  import vi_mem_pkg::*;
(
`ifdef VI_MEM_ARB_RR_EN
  input  logic   clk_i,
  input  logic   rsn_i,
`endif
  input  logic   en_i,
  input  logic   ic_req_i,
  input  logic   dc_req_i,
  output logic   valid_o,
  output owner_t owner_o
);

`ifdef VI_MEM_ARB_RR_EN

  owner_t ptr_q, ptr_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch cannot be inferred.
    valid_o = en_i && (ic_req_i || dc_req_i);
    owner_o = OWN_IC;
    ptr_d   = ptr_q;

    if (ic_req_i && dc_req_i) begin
      owner_o = ptr_q;
    end else if (dc_req_i) begin
      owner_o = OWN_DC;
    end

    if (valid_o) begin
      ptr_d = other_owner(owner_o);
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the clock edge, independent of block order.
    if (!rsn_i) begin
      ptr_q <= OWN_IC;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`else

  // Data traffic always wins a tie; fetch waits until the D-cache is quiet.
  always_comb begin
    valid_o = en_i && (ic_req_i || dc_req_i);
    owner_o = dc_req_i ? OWN_DC : OWN_IC;
  end

`endif

endmodule

// File: rtl/vi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vi_mem_arbiter
// Shares vi_core's single external memory port between the I-cache refill
// path and the D-cache (line refills plus word/byte stores). At most one read
// is in flight; the returned line is routed to the cache that issued it.
// Stores are fire-and-forget single-cycle write strobes.
// Build option: VI_MEM_ARB_RR_EN selects round-robin between the caches;
// otherwise the D-cache has fixed priority (see vi_mem_arb_pick).
// Ports:
//   clk_i, rsn_i           : clock, asynchronous active-low reset
//   ic_req_i / ic_addr_i   : I-cache line read request (level, held to ready)
//   ic_grant_o / ic_ready_o: one-cycle accept / data-valid pulses
//   ic_data_o              : last line returned to the I-cache
//   dc_rd_req_i / _addr_i  : D-cache line read request (level, held to ready)
//   dc_wr_req_i / _addr_i / _data_i / _byte_i : D-cache store (held to grant)
//   dc_grant_o / dc_ready_o: one-cycle accept / data-valid pulses
//   dc_data_o              : last line returned to the D-cache
//   mem                    : memory port (vi_mem_arbiter_if, master side)
// All outputs are registered.
// -----------------------------------------------------------------------------
module vi_mem_arbiter
  import vi_mem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rsn_i,

  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_grant_o,
  output logic              ic_ready_o,
  output logic [LINE_W-1:0] ic_data_o,

  input  logic              dc_rd_req_i,
  input  logic [ADDR_W-1:0] dc_rd_addr_i,
  input  logic              dc_wr_req_i,
  input  logic [ADDR_W-1:0] dc_wr_addr_i,
  input  logic [WORD_W-1:0] dc_wr_data_i,
  input  logic              dc_wr_byte_i,
  output logic              dc_grant_o,
  output logic              dc_ready_o,
  output logic [LINE_W-1:0] dc_data_o,

  vi_mem_arbiter_if.master  mem
);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;        // address of the read in flight

  logic              ic_grant_q, ic_grant_d;
  logic              ic_ready_q, ic_ready_d;
  logic [LINE_W-1:0] ic_data_q,  ic_data_d;
  logic              dc_grant_q, dc_grant_d;
  logic              dc_ready_q, dc_ready_d;
  logic [LINE_W-1:0] dc_data_q,  dc_data_d;

  logic              rd_q,     rd_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              we_q,     we_d;
  logic              wbyte_q,  wbyte_d;
  logic [ADDR_W-1:0] waddr_q,  waddr_d;
  logic [WORD_W-1:0] wdata_q,  wdata_d;

  // ---------------------------------------------------------------------------
  // Arbitration: only consulted in IDLE, so a second read can never be issued
  // while one is outstanding.
  // ---------------------------------------------------------------------------
  logic   pick_valid;
  owner_t pick_owner;

  vi_mem_arb_pick u_pick (
`ifdef VI_MEM_ARB_RR_EN
    .clk_i    (clk_i),
    .rsn_i    (rsn_i),
`endif
    .en_i     (state_q == IDLE),
    .ic_req_i (ic_req_i),
    .dc_req_i (dc_rd_req_i || dc_wr_req_i),
    .valid_o  (pick_valid),
    .owner_o  (pick_owner)
  );

  logic resp_match;
  assign resp_match = mem.mem_data_ready && (mem.mem_addr == addr_q);

  // ---------------------------------------------------------------------------
  // Next state and next outputs. Outputs are computed for the state being
  // entered so that they appear, registered, during that state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;

    ic_grant_d = 1'b0;
    ic_ready_d = 1'b0;
    ic_data_d  = ic_data_q;
    dc_grant_d = 1'b0;
    dc_ready_d = 1'b0;
    dc_data_d  = dc_data_q;

    // Strobe qualifiers are driven only alongside their strobe.
    rd_d       = 1'b0;
    rd_addr_d  = '0;
    we_d       = 1'b0;
    wbyte_d    = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_owner;
          if (pick_owner == OWN_IC) begin
            addr_d     = ic_addr_i;
            rd_d       = 1'b1;
            rd_addr_d  = ic_addr_i;
            ic_grant_d = 1'b1;
            state_d    = RD_ISSUE;
          end else if (dc_wr_req_i) begin
            // A pending store drains ahead of the D-cache refill.
            we_d       = 1'b1;
            wbyte_d    = dc_wr_byte_i;
            waddr_d    = dc_wr_addr_i;
            wdata_d    = dc_wr_data_i;
            dc_grant_d = 1'b1;
            state_d    = WR_ISSUE;
          end else begin
            addr_d     = dc_rd_addr_i;
            rd_d       = 1'b1;
            rd_addr_d  = dc_rd_addr_i;
            dc_grant_d = 1'b1;
            state_d    = RD_ISSUE;
          end
        end
      end

      RD_ISSUE: begin
        state_d = RD_WAIT;
      end

      RD_WAIT: begin
        // Responses carrying another address are stale and dropped.
        if (resp_match) begin
          if (owner_q == OWN_IC) begin
            ic_data_d  = mem.mem_data;
            ic_ready_d = 1'b1;
          end else begin
            dc_data_d  = mem.mem_data;
            dc_ready_d = 1'b1;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      WR_ISSUE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IC;
      addr_q     <= '0;
      ic_grant_q <= 1'b0;
      ic_ready_q <= 1'b0;
      ic_data_q  <= '0;
      dc_grant_q <= 1'b0;
      dc_ready_q <= 1'b0;
      dc_data_q  <= '0;
      rd_q       <= 1'b0;
      rd_addr_q  <= '0;
      we_q       <= 1'b0;
      wbyte_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      ic_grant_q <= ic_grant_d;
      ic_ready_q <= ic_ready_d;
      ic_data_q  <= ic_data_d;
      dc_grant_q <= dc_grant_d;
      dc_ready_q <= dc_ready_d;
      dc_data_q  <= dc_data_d;
      rd_q       <= rd_d;
      rd_addr_q  <= rd_addr_d;
      we_q       <= we_d;
      wbyte_q    <= wbyte_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ic_grant_o           = ic_grant_q;
  assign ic_ready_o           = ic_ready_q;
  assign ic_data_o            = ic_data_q;
  assign dc_grant_o           = dc_grant_q;
  assign dc_ready_o           = dc_ready_q;
  assign dc_data_o            = dc_data_q;

  assign mem.mem_read         = rd_q;
  assign mem.mem_read_addr    = rd_addr_q;
  assign mem.mem_write_enable = we_q;
  assign mem.mem_write_byte   = wbyte_q;
  assign mem.mem_write_addr   = waddr_q;
  assign mem.mem_write_data   = wdata_q;

endmodule

// File: tb/tb_vi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vi_mem_arbiter
// Directed bench for vi_mem_arbiter: a table of single transactions followed
// by hand-written sequences for stores vs refills, stale responses, reset in
// flight, idle responses and arbitration order. Inputs are driven and outputs
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_vi_mem_arbiter;
  import vi_mem_pkg::*;

  logic              clk;
  logic              rsn;
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_grant, ic_ready;
  logic [LINE_W-1:0] ic_data;
  logic              dc_rd_req;
  logic [ADDR_W-1:0] dc_rd_addr;
  logic              dc_wr_req;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [WORD_W-1:0] dc_wr_data;
  logic              dc_wr_byte;
  logic              dc_grant, dc_ready;
  logic [LINE_W-1:0] dc_data;

  vi_mem_arbiter_if mem_if ();

  vi_mem_arbiter dut (
    .clk_i        (clk),
    .rsn_i        (rsn),
    .ic_req_i     (ic_req),
    .ic_addr_i    (ic_addr),
    .ic_grant_o   (ic_grant),
    .ic_ready_o   (ic_ready),
    .ic_data_o    (ic_data),
    .dc_rd_req_i  (dc_rd_req),
    .dc_rd_addr_i (dc_rd_addr),
    .dc_wr_req_i  (dc_wr_req),
    .dc_wr_addr_i (dc_wr_addr),
    .dc_wr_data_i (dc_wr_data),
    .dc_wr_byte_i (dc_wr_byte),
    .dc_grant_o   (dc_grant),
    .dc_ready_o   (dc_ready),
    .dc_data_o    (dc_data),
    .mem          (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Every control output and strobe-qualified bus packed together.
  function automatic logic [127:0] ctl_bus();
    return 128'({ic_grant, ic_ready, dc_grant, dc_ready,
                 mem_if.mem_read, mem_if.mem_write_enable, mem_if.mem_write_byte,
                 mem_if.mem_read_addr, mem_if.mem_write_addr, mem_if.mem_write_data});
  endfunction

  function automatic logic [127:0] readies();
    return 128'({ic_ready, dc_ready});
  endfunction

  // Line the bench memory returns for an address in the arbitration sequence.
  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {4{12'hA5C, a}};
  endfunction

  // ---------------------------------------------------------------------------
  // Single-transaction vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    int                kind;   // 0 I-cache read, 1 D-cache read, 2 D-cache store
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              wbyte;
    logic [LINE_W-1:0] line;   // memory response for reads
    int                delay;  // falling edges from read strobe to response (>=1)
    logic [LINE_W-1:0] exp_ic_data;
    logic [LINE_W-1:0] exp_dc_data;
  } vec_t;

  localparam logic [LINE_W-1:0] L0 = 128'h00311133_00F00193_00108113_001000B3;
  localparam logic [LINE_W-1:0] L1 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [LINE_W-1:0] L2 = 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0;
  localparam logic [LINE_W-1:0] L3 = 128'h0F0F0F0F_F0F0F0F0_00FF00FF_FF00FF00;
  localparam logic [LINE_W-1:0] L4 = 128'hDEAD0001_DEAD0002_DEAD0003_DEAD0004;
  localparam logic [LINE_W-1:0] L5 = 128'h55AA55AA_AA55AA55_13579BDF_2468ACE0;
  localparam logic [LINE_W-1:0] L5_STALE = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
  localparam logic [LINE_W-1:0] L6 = 128'h66666666_77777777_88888888_99999999;
  localparam logic [LINE_W-1:0] L7 = 128'h0000FFFF_FFFF0000_0000FFFF_FFFF0000;

  task automatic apply_vec(input string tag, input vec_t v);
    case (v.kind)
      0: begin ic_req = 1'b1; ic_addr = v.addr; end
      1: begin dc_rd_req = 1'b1; dc_rd_addr = v.addr; end
      default: begin
        dc_wr_req = 1'b1; dc_wr_addr = v.addr; dc_wr_data = v.wdata; dc_wr_byte = v.wbyte;
      end
    endcase
    tick();
    if (v.kind == 2) begin
      check({tag, "_we"},    128'(mem_if.mem_write_enable), 128'(1));
      check({tag, "_waddr"}, 128'(mem_if.mem_write_addr),   128'(v.addr));
      check({tag, "_wdata"}, 128'(mem_if.mem_write_data),   128'(v.wdata));
      check({tag, "_wbyte"}, 128'(mem_if.mem_write_byte),   128'(v.wbyte));
      check({tag, "_grants"}, 128'({ic_grant, dc_grant, mem_if.mem_read}), 128'(3'b010));
      dc_wr_req = 1'b0;
      tick();
      check({tag, "_wr_pulse_end"}, 128'({mem_if.mem_write_enable, dc_grant}), '0);
    end else begin
      check({tag, "_rd"},     128'(mem_if.mem_read),      128'(1));
      check({tag, "_raddr"},  128'(mem_if.mem_read_addr), 128'(v.addr));
      check({tag, "_grants"}, 128'({ic_grant, dc_grant, mem_if.mem_write_enable}),
            128'({v.kind == 0, v.kind == 1, 1'b0}));
      tick();
      check({tag, "_rd_pulse_end"}, 128'({mem_if.mem_read, ic_grant, dc_grant}), '0);
      repeat (v.delay - 1) begin
        check({tag, "_early_ready"}, readies(), '0);
        tick();
      end
      mem_if.mem_data_ready = 1'b1;
      mem_if.mem_addr       = v.addr;
      mem_if.mem_data       = v.line;
      tick();
      mem_if.mem_data_ready = 1'b0;
      check({tag, "_ready"}, readies(), 128'({v.kind == 0, v.kind == 1}));
      ic_req    = 1'b0;
      dc_rd_req = 1'b0;
      tick();
      check({tag, "_ready_pulse_end"}, readies(), '0);
    end
    check({tag, "_ic_data"}, ic_data, v.exp_ic_data);
    check({tag, "_dc_data"}, dc_data, v.exp_dc_data);
  endtask

  vec_t vecs[6];
  vec_t post_rst_rd;
  vec_t post_idle_wr;
  int   exp_order[8];
  int   order[$];

  initial begin
    vecs[0] = '{kind: 0, addr: 20'h01000, wdata: '0, wbyte: 1'b0, line: L0, delay: 2,
                exp_ic_data: L0, exp_dc_data: '0};
    vecs[1] = '{kind: 1, addr: 20'h08000, wdata: '0, wbyte: 1'b0, line: L1, delay: 1,
                exp_ic_data: L0, exp_dc_data: L1};
    vecs[2] = '{kind: 2, addr: 20'h00123, wdata: 32'h000000AA, wbyte: 1'b1, line: '0, delay: 1,
                exp_ic_data: L0, exp_dc_data: L1};
    vecs[3] = '{kind: 2, addr: 20'h00400, wdata: 32'hDEADBEEF, wbyte: 1'b0, line: '0, delay: 1,
                exp_ic_data: L0, exp_dc_data: L1};
    vecs[4] = '{kind: 0, addr: 20'hFFFF0, wdata: '0, wbyte: 1'b0, line: L2, delay: 3,
                exp_ic_data: L2, exp_dc_data: L1};
    vecs[5] = '{kind: 1, addr: 20'h00000, wdata: '0, wbyte: 1'b0, line: L3, delay: 1,
                exp_ic_data: L2, exp_dc_data: L3};
    post_rst_rd  = '{kind: 0, addr: 20'h05000, wdata: '0, wbyte: 1'b0, line: L6, delay: 1,
                     exp_ic_data: L6, exp_dc_data: '0};
    post_idle_wr = '{kind: 2, addr: 20'h00124, wdata: 32'h12345678, wbyte: 1'b0, line: '0, delay: 1,
                     exp_ic_data: L6, exp_dc_data: '0};
`ifdef VI_MEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{1, 1, 1, 1, 0, 0, 0, 0};
`endif

    rsn = 1'b0;
    ic_req = 1'b0; ic_addr = '0;
    dc_rd_req = 1'b0; dc_rd_addr = '0;
    dc_wr_req = 1'b0; dc_wr_addr = '0; dc_wr_data = '0; dc_wr_byte = 1'b0;
    mem_if.mem_data_ready = 1'b0; mem_if.mem_addr = '0; mem_if.mem_data = '0;

    // Reset state
    repeat (2) tick();
    check("reset_ctl", ctl_bus(), '0);
    check("reset_ic_data", ic_data, '0);
    check("reset_dc_data", dc_data, '0);
    rsn = 1'b1;
    tick();

    // Table of single transactions
    for (int i = 0; i < 6; i++) begin
      apply_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Store and refill raised together: store first, read two cycles later
    dc_wr_req = 1'b1; dc_wr_addr = 20'h00123; dc_wr_data = 32'h000000AA; dc_wr_byte = 1'b1;
    dc_rd_req = 1'b1; dc_rd_addr = 20'h08000;
    tick();
    check("wr_first_we", 128'({mem_if.mem_write_enable, mem_if.mem_write_byte, mem_if.mem_read}), 128'(3'b110));
    check("wr_first_addr", 128'(mem_if.mem_write_addr), 128'(20'h00123));
    check("wr_first_grant", 128'(dc_grant), 128'(1));
    dc_wr_req = 1'b0;
    tick();
    check("wr_gap", 128'({mem_if.mem_write_enable, mem_if.mem_read, dc_grant}), '0);
    tick();
    check("rd_after_wr", 128'({mem_if.mem_read, dc_grant}), 128'(2'b11));
    check("rd_after_wr_addr", 128'(mem_if.mem_read_addr), 128'(20'h08000));
    tick();
    mem_if.mem_data_ready = 1'b1; mem_if.mem_addr = 20'h08000; mem_if.mem_data = L4;
    tick();
    mem_if.mem_data_ready = 1'b0;
    check("rd_after_wr_ready", readies(), 128'(2'b01));
    check("rd_after_wr_data", dc_data, L4);
    dc_rd_req = 1'b0;
    tick();

    // Stale response is ignored, matching one completes the read
    ic_req = 1'b1; ic_addr = 20'h02000;
    tick();
    check("stale_grant", 128'(ic_grant), 128'(1));
    tick();
    mem_if.mem_data_ready = 1'b1; mem_if.mem_addr = 20'h03000; mem_if.mem_data = L5_STALE;
    tick();
    check("stale_no_ready", readies(), '0);
    mem_if.mem_addr = 20'h02000; mem_if.mem_data = L5;
    tick();
    mem_if.mem_data_ready = 1'b0;
    check("stale_match_ready", readies(), 128'(2'b10));
    check("stale_match_data", ic_data, L5);
    ic_req = 1'b0;
    tick();

    // Reset asserted while waiting for a response
    ic_req = 1'b1; ic_addr = 20'h04000;
    tick();
    tick();
    rsn = 1'b0;
    ic_req = 1'b0;
    mem_if.mem_data_ready = 1'b1; mem_if.mem_addr = 20'h04000; mem_if.mem_data = L7;
    #1;
    check("midrst_ctl", ctl_bus(), '0);
    check("midrst_ic_data", ic_data, '0);
    check("midrst_dc_data", dc_data, '0);
    tick();
    rsn = 1'b1;
    tick();
    mem_if.mem_data_ready = 1'b0;
    check("midrst_no_ready_a", readies(), '0);
    tick();
    check("midrst_no_ready_b", readies(), '0);
    check("midrst_ic_data_kept", ic_data, '0);
    apply_vec("post_rst", post_rst_rd);

    // Response while idle has no effect
    mem_if.mem_data_ready = 1'b1; mem_if.mem_addr = 20'h05000; mem_if.mem_data = L7;
    tick();
    mem_if.mem_data_ready = 1'b0;
    check("idle_resp_no_ready_a", readies(), '0);
    tick();
    check("idle_resp_no_ready_b", readies(), '0);
    check("idle_resp_ic_data", ic_data, L6);
    apply_vec("post_idle", post_idle_wr);

    // Arbitration order with both caches requesting continuously
    rsn = 1'b0;
    tick();
    rsn = 1'b1;
    tick();
    begin
      int ic_left = 4;
      int dc_left = 4;
      int cyc = 0;
      int resp_at = -1;
      logic [ADDR_W-1:0] resp_addr = '0;
      ic_req = 1'b1; ic_addr = 20'h10000;
      dc_rd_req = 1'b1; dc_rd_addr = 20'h20000;
      while ((ic_left > 0 || dc_left > 0) && cyc < 200) begin
        tick();
        cyc++;
        mem_if.mem_data_ready = 1'b0;
        if (ic_grant) order.push_back(0);
        if (dc_grant) order.push_back(1);
        if (mem_if.mem_read) begin
          resp_at = cyc + 1;
          resp_addr = mem_if.mem_read_addr;
        end
        if (ic_ready) begin
          check("arb_ic_line", ic_data, line_of(ic_addr));
          ic_left--;
          if (ic_left == 0) ic_req = 1'b0;
          else ic_addr = ic_addr + 20'h10;
        end
        if (dc_ready) begin
          check("arb_dc_line", dc_data, line_of(dc_rd_addr));
          dc_left--;
          if (dc_left == 0) dc_rd_req = 1'b0;
          else dc_rd_addr = dc_rd_addr + 20'h10;
        end
        if (cyc == resp_at) begin
          mem_if.mem_data_ready = 1'b1;
          mem_if.mem_addr = resp_addr;
          mem_if.mem_data = line_of(resp_addr);
        end
      end
      mem_if.mem_data_ready = 1'b0;
      ic_req = 1'b0;
      dc_rd_req = 1'b0;
      check("arb_all_done", 128'(ic_left == 0 && dc_left == 0), 128'(1));
      check("arb_grant_count", 128'(order.size()), 128'(8));
      for (int i = 0; i < 8; i++) begin
        if (i < order.size()) begin
          check($sformatf("arb_order_%0d", i), 128'(order[i]), 128'(exp_order[i]));
        end
      end
    end

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
